// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running h/v counters, line/frame strobes, and
// sync/DE aligned to the renderer's registered RGB through a short delay line.
module video_timing_gen #(
    parameter int unsigned H_ACTIVE = 1024,
    parameter int unsigned H_FP     = 24,
    parameter int unsigned H_SYNC   = 136,
    parameter int unsigned H_BP     = 160,
    parameter int unsigned V_ACTIVE = 768,
    parameter int unsigned V_FP     = 3,
    parameter int unsigned V_SYNC   = 6,
    parameter int unsigned V_BP     = 29,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned PIPE_DLY = 2
) (
    input  logic        i_clk_74M,
    input  logic        i_rst,
    output logic [11:0] o_hcnt,
    output logic [11:0] o_vcnt,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_de,
    output logic        o_line_start,
    output logic        o_frame_start
);

    localparam int unsigned CNT_W   = 12;
    localparam int unsigned CNT_MAX = 4095;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    // Reject timings whose totals do not fit the 12-bit counters.
    if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_bad_total
        $error("video_timing_gen: H_TOTAL/V_TOTAL must be <= 4095");
    end
    if (PIPE_DLY > 7) begin : g_bad_dly
        $error("video_timing_gen: PIPE_DLY must be 0..7");
    end

    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] vcnt;
    logic             de_raw;
    logic             hs_raw;
    logic             vs_raw;
    logic             hs_lvl;
    logic             vs_lvl;

    // Free-running raster counters.
    always_ff @(posedge i_clk_74M) begin
        if (i_rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + CNT_W'(1);
        end else begin
            hcnt <= hcnt + CNT_W'(1);
        end
    end

    // Undelayed decode; forced inactive while reset is held so zero-delay builds stay quiet.
    always_comb begin
        de_raw = 1'b0;
        hs_raw = 1'b0;
        vs_raw = 1'b0;
        if (!i_rst) begin
            de_raw = (hcnt < H_ACT) && (vcnt < V_ACT);
            hs_raw = (hcnt >= HS_START) && (hcnt < HS_END);
            vs_raw = (vcnt >= VS_START) && (vcnt < VS_END);
        end
    end

    assign hs_lvl = hs_raw ? HS_POL : ~HS_POL;
    assign vs_lvl = vs_raw ? VS_POL : ~VS_POL;

    assign o_hcnt        = hcnt;
    assign o_vcnt        = vcnt;
    assign o_line_start  = !i_rst && (hcnt == '0);
    assign o_frame_start = !i_rst && (hcnt == '0) && (vcnt == '0);

    if (PIPE_DLY == 0) begin : g_nodly
        assign o_vsync = vs_lvl;
        assign o_hsync = hs_lvl;
        assign o_de    = de_raw;
    end else begin : g_dly
        localparam logic [2:0] IDLE = {~VS_POL, ~HS_POL, 1'b0};

        // Each stage carries {vsync, hsync, de}.
        logic [2:0] sr [PIPE_DLY];

        always_ff @(posedge i_clk_74M) begin
            if (i_rst) begin
                for (int i = 0; i < PIPE_DLY; i++) begin
                    sr[i] <= IDLE;
                end
            end else begin
                sr[0] <= {vs_lvl, hs_lvl, de_raw};
                for (int i = 1; i < PIPE_DLY; i++) begin
                    sr[i] <= sr[i-1];
                end
            end
        end

        assign {o_vsync, o_hsync, o_de} = sr[PIPE_DLY-1];
    end

endmodule
